// File: rtl/button_event_pkg.sv
// Shared types for the button gesture classifier.
package button_event_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StWait2,
    StPress2,
    StLHold
  } state_t;

  typedef enum logic [1:0] {
    EvtNone   = 2'b00,
    EvtShort  = 2'b01,
    EvtLong   = 2'b10,
    EvtDouble = 2'b11
  } evt_t;

endpackage

// File: rtl/button_event_if.sv
// Valid/ready event slot between the gesture classifier and its consumer.
interface button_event_if;
  import button_event_pkg::*;

  logic evt_valid;
  evt_t evt_code;
  logic evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/button_event_evt_slot.sv
// One-deep event holding register with sticky overrun on a dropped event.
module button_event_evt_slot
  import button_event_pkg::*;
(
  input  logic clk50m,
  input  logic rst_n,
  input  logic emit_i,
  input  evt_t code_i,
  input  logic evt_ready_i,
  input  logic ovr_clr_i,
  output logic evt_valid_o,
  output evt_t evt_code_o,
  output logic ovr_o
);

  logic valid_q, valid_d;
  evt_t code_q, code_d;
  logic ovr_q, ovr_d;
  logic accept, drop;

  always_comb begin
    accept  = valid_q & evt_ready_i;
    drop    = emit_i & valid_q & ~evt_ready_i;
    valid_d = valid_q;
    code_d  = code_q;
    // An accept in the emit cycle frees the slot, so the new event loads with no gap.
    if (emit_i && (!valid_q || evt_ready_i)) begin
      valid_d = 1'b1;
      code_d  = code_i;
    end else if (accept) begin
      valid_d = 1'b0;
      code_d  = EvtNone;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= EvtNone;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_code_o  = code_q;
  assign ovr_o       = ovr_q;

endmodule

// File: rtl/button_event.sv
// Classifies debounced switch gestures as SHORT, LONG or DOUBLE and queues one event.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned DCLK_CYC = 15_000_000
) (
  input  logic                  clk50m,
  input  logic                  rst_n,
  input  logic                  sw_dbnc_i,
  input  logic                  ovr_clr_i,
  output logic                  held_o,
  output logic                  ovr_o,
  button_event_if.master        evt_if
);

  localparam int unsigned CNT_W = $clog2(LONG_CYC);
  localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DclkMax = CNT_W'(DCLK_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic             sw_q;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit;
  evt_t             code;

  assign rise = sw_dbnc_i & ~sw_q;
  assign fall = ~sw_dbnc_i & sw_q;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    code    = EvtNone;
    case (state_q)
      StIdle: begin
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall) begin
          state_d = StWait2;
        end else if (cnt_q == LongMax) begin
          emit    = 1'b1;
          code    = EvtLong;
          state_d = StLHold;
        end
      end
      StWait2: begin
        if (rise) begin
          state_d = StPress2;
        end else if (cnt_q == DclkMax) begin
          emit    = 1'b1;
          code    = EvtShort;
          state_d = StIdle;
        end
      end
      StPress2: begin
        if (fall) begin
          emit    = 1'b1;
          code    = EvtDouble;
          state_d = StIdle;
        end else if (cnt_q == LongMax) begin
          emit    = 1'b1;
          code    = EvtLong;
          state_d = StLHold;
        end
      end
      StLHold: begin
        if (fall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Counter measures time in the current state; it saturates rather than wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // sw_q resets high so a switch held through reset does not look like a fresh press.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sw_q    <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      sw_q    <= sw_dbnc_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = (state_q == StLHold);

  button_event_evt_slot u_evt_slot (
    .clk50m      (clk50m),
    .rst_n       (rst_n),
    .emit_i      (emit),
    .code_i      (code),
    .evt_ready_i (evt_if.evt_ready),
    .ovr_clr_i   (ovr_clr_i),
    .evt_valid_o (evt_if.evt_valid),
    .evt_code_o  (evt_if.evt_code),
    .ovr_o       (ovr_o)
  );

endmodule

// File: tb/tb_button_event.sv
// Gesture bench: waveforms built from gesture descriptions, expected events derived from timing rules.
module tb_button_event;
  import button_event_pkg::*;

  localparam int unsigned LongCyc = 20;
  localparam int unsigned DclkCyc = 8;
  localparam int unsigned MaxLen  = 4096;

  logic clk50m  = 1'b0;
  logic rst_n   = 1'b0;
  logic sw_dbnc = 1'b0;
  logic ovr_clr = 1'b0;
  logic held;
  logic ovr;

  button_event_if bus ();

  button_event #(
    .LONG_CYC (LongCyc),
    .DCLK_CYC (DclkCyc)
  ) dut (
    .clk50m    (clk50m),
    .rst_n     (rst_n),
    .sw_dbnc_i (sw_dbnc),
    .ovr_clr_i (ovr_clr),
    .held_o    (held),
    .ovr_o     (ovr),
    .evt_if    (bus)
  );

  always #10 clk50m = ~clk50m;

  // Per-cycle stimulus and expectations for one run.
  logic       w_a    [MaxLen];
  logic       rdy_a  [MaxLen];
  logic       clr_a  [MaxLen];
  logic       held_a [MaxLen];
  logic [1:0] emit_a [MaxLen];
  int         len;
  int         last_emit;

  // Output slot model.
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_ovr;

  int checks;
  int errors;

  task automatic chk(input string tag, input int cyc, input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic new_run();
    len = 0;
    for (int i = 0; i < int'(MaxLen); i++) begin
      w_a[i]    = 1'b0;
      rdy_a[i]  = 1'b1;
      clr_a[i]  = 1'b0;
      held_a[i] = 1'b0;
      emit_a[i] = EvtNone;
    end
  endtask

  task automatic lvl(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      w_a[len] = v;
      len++;
    end
  endtask

  task automatic mark_held(input int a, input int b);
    for (int k = a; k <= b; k++) held_a[k] = 1'b1;
  endtask

  // High h then low g > DclkCyc: SHORT decided DclkCyc edges after the fall.
  task automatic g_short(input int h, input int g);
    int p;
    p = len;
    last_emit = p + h + int'(DclkCyc);
    emit_a[last_emit] = EvtShort;
    lvl(1'b1, h);
    lvl(1'b0, g);
  endtask

  // High h > LongCyc: LONG decided LongCyc edges after the rise, held until the fall.
  task automatic g_long(input int h, input int lo);
    int p;
    p = len;
    last_emit = p + int'(LongCyc);
    emit_a[last_emit] = EvtLong;
    mark_held(p + int'(LongCyc), p + h - 1);
    lvl(1'b1, h);
    lvl(1'b0, lo);
  endtask

  // Two presses with gap g <= DclkCyc; a second press longer than LongCyc becomes LONG.
  task automatic g_double(input int h1, input int g, input int h2, input int lo);
    int r;
    r = len + h1 + g;
    if (h2 <= int'(LongCyc)) begin
      last_emit = r + h2;
      emit_a[last_emit] = EvtDouble;
    end else begin
      last_emit = r + int'(LongCyc);
      emit_a[last_emit] = EvtLong;
      mark_held(r + int'(LongCyc), r + h2 - 1);
    end
    lvl(1'b1, h1);
    lvl(1'b0, g);
    lvl(1'b1, h2);
    lvl(1'b0, lo);
  endtask

  task automatic play();
    logic accept;
    logic emit;
    logic drop;
    for (int k = 0; k < len; k++) begin
      sw_dbnc       = w_a[k];
      bus.evt_ready = rdy_a[k];
      ovr_clr       = clr_a[k];
      @(posedge clk50m);
      emit   = (emit_a[k] != EvtNone);
      accept = m_valid && rdy_a[k];
      drop   = emit && m_valid && !rdy_a[k];
      if (emit && !drop) begin
        m_valid = 1'b1;
        m_code  = emit_a[k];
      end else if (accept) begin
        m_valid = 1'b0;
        m_code  = EvtNone;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_a[k]) m_ovr = 1'b0;
      @(negedge clk50m);
      chk("evt_valid", k, {1'b0, bus.evt_valid}, {1'b0, m_valid});
      chk("evt_code", k, bus.evt_code, m_code);
      chk("held", k, {1'b0, held}, {1'b0, held_a[k]});
      chk("ovr", k, {1'b0, ovr}, {1'b0, m_ovr});
    end
  endtask

  task automatic do_reset();
    @(negedge clk50m);
    rst_n = 1'b0;
    #2;
    chk("rst_valid", -1, {1'b0, bus.evt_valid}, 2'b00);
    chk("rst_code", -1, bus.evt_code, EvtNone);
    chk("rst_held", -1, {1'b0, held}, 2'b00);
    chk("rst_ovr", -1, {1'b0, ovr}, 2'b00);
    m_valid = 1'b0;
    m_code  = EvtNone;
    m_ovr   = 1'b0;
    @(negedge clk50m);
    rst_n = 1'b1;
  endtask

  initial begin
    int e2;
    int c;
    checks        = 0;
    errors        = 0;
    bus.evt_ready = 1'b1;
    do_reset();

    // Short, long and double click.
    new_run(); lvl(1'b0, 2); g_short(5, 10); lvl(1'b0, 3); play();
    new_run(); lvl(1'b0, 1); g_long(30, 4); play();
    new_run(); lvl(1'b0, 1); g_double(3, 3, 3, 5); play();

    // Threshold boundaries on press length and click gap.
    new_run();
    lvl(1'b0, 1);
    g_short(int'(LongCyc), int'(DclkCyc) + 1);
    g_double(2, int'(DclkCyc), int'(LongCyc), 3);
    g_long(int'(LongCyc) + 1, 2);
    g_double(2, 1, int'(LongCyc) + 1, 2);
    play();

    // Pending SHORT replaced by DOUBLE in the accept cycle.
    new_run();
    lvl(1'b0, 1);
    g_short(5, 10);
    g_double(3, 3, 3, 4);
    e2 = last_emit;
    for (int k = 0; k < e2; k++) rdy_a[k] = 1'b0;
    play();

    // Overrun with clear colliding with the drop, later clear, then a press left open.
    new_run();
    lvl(1'b0, 1);
    g_short(5, 10);
    g_short(4, 10);
    e2 = last_emit;
    lvl(1'b0, 3);
    c = len;
    lvl(1'b0, 3);
    lvl(1'b1, 5);
    for (int k = 0; k < len; k++) rdy_a[k] = 1'b0;
    clr_a[e2] = 1'b1;
    clr_a[c]  = 1'b1;
    play();

    // Reset mid-press with the switch kept high: no event until a fresh press.
    do_reset();
    new_run();
    lvl(1'b1, 30);
    lvl(1'b0, 3);
    g_short(6, 9);
    lvl(1'b0, 2);
    play();

    // Random gestures with random consumer stalls and clears.
    new_run();
    lvl(1'b0, 2);
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: g_short(int'($urandom_range(1, LongCyc)),
                   int'($urandom_range(DclkCyc + 1, DclkCyc + 6)));
        1: g_long(int'($urandom_range(LongCyc + 1, LongCyc + 8)), int'($urandom_range(1, 4)));
        2: g_double(int'($urandom_range(1, LongCyc)), int'($urandom_range(1, DclkCyc)),
                    int'($urandom_range(1, LongCyc)), int'($urandom_range(1, 4)));
        default: g_double(int'($urandom_range(1, LongCyc)), int'($urandom_range(1, DclkCyc)),
                          int'($urandom_range(LongCyc + 1, LongCyc + 6)),
                          int'($urandom_range(1, 4)));
      endcase
    end
    lvl(1'b0, 3);
    for (int k = 0; k < len; k++) begin
      rdy_a[k] = ($urandom_range(0, 3) != 0);
      clr_a[k] = ($urandom_range(0, 7) == 0);
    end
    play();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
